// File: rtl/tt_event_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tt_event_pkg
// Description : Shared constants and channel helpers for tag-time event
//               streams. Channels are signed: +1..+18 rising edge,
//               -1..-18 falling edge. Enable-mask layout: bit c-1 enables
//               rising channel c, bit 17+c enables falling channel -c.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_event_pkg;

  localparam int NUM_CHANNELS = 18;
  localparam int MASK_WIDTH   = 36;
  localparam int CHAN_WIDTH   = 6;
  localparam int TIME_WIDTH   = 64;

  // A channel is valid when 1 <= |ch| <= NUM_CHANNELS. Zero and anything
  // beyond the physical channel count are rejected.
  function automatic logic chan_is_valid(input logic signed [CHAN_WIDTH-1:0] ch);
    return (ch != 6'sd0) && (ch >= -6'sd18) && (ch <= 6'sd18);
  endfunction

  // Bit index into the enable mask for a channel. Invalid channels map to
  // bit 0; callers must gate the result with chan_is_valid().
  function automatic logic [5:0] chan_to_mask_bit(input logic signed [CHAN_WIDTH-1:0] ch);
    logic signed [CHAN_WIDTH-1:0] neg;
    if (!chan_is_valid(ch)) begin
      return 6'd0;
    end
    if (ch > 6'sd0) begin
      return $unsigned(ch) - 6'd1;
    end
    neg = -ch;
    return 6'd17 + $unsigned(neg);
  endfunction

endpackage : tt_event_pkg
`default_nettype wire

// File: rtl/lane_compactor.sv
`default_nettype none
// ============================================================================
// Module      : lane_compactor
// Description : One register stage that packs kept lanes into the low lanes
//               of the output word, preserving their relative order. Unused
//               output lanes carry zero data and a zero keep bit.
// Revision    : 1.0 - initial release
// Ports       : clk, rst        - clock, async active-high reset
//               in_keep         - per-lane keep vector
//               in_tagtime      - lane tag times (TIME_WIDTH per lane)
//               in_channel      - lane channels (CHAN_WIDTH per lane)
//               out_valid       - at least one lane kept
//               out_tagtime     - compacted tag times
//               out_channel     - compacted channels
//               out_keep        - thermometer code, lanes 0..count-1 set
//               out_count       - number of kept lanes
// ============================================================================
module lane_compactor
  import tt_event_pkg::*;
#(
  parameter int WORD_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WORD_WIDTH-1:0]              in_keep,
  input  logic [TIME_WIDTH*WORD_WIDTH-1:0]   in_tagtime,
  input  logic [CHAN_WIDTH*WORD_WIDTH-1:0]   in_channel,
  output logic                               out_valid,
  output logic [TIME_WIDTH*WORD_WIDTH-1:0]   out_tagtime,
  output logic [CHAN_WIDTH*WORD_WIDTH-1:0]   out_channel,
  output logic [WORD_WIDTH-1:0]              out_keep,
  output logic [$clog2(WORD_WIDTH+1)-1:0]    out_count
);

  localparam int KW = $clog2(WORD_WIDTH + 1);

  logic                             valid_d,   valid_q;
  logic [TIME_WIDTH*WORD_WIDTH-1:0] tagtime_d, tagtime_q;
  logic [CHAN_WIDTH*WORD_WIDTH-1:0] channel_d, channel_q;
  logic [WORD_WIDTH-1:0]            keep_d,    keep_q;
  logic [KW-1:0]                    count_d,   count_q;

  // Walking count doubles as the destination lane: each kept lane lands at
  // the number of kept lanes below it.
  always_comb begin
    tagtime_d = '0;
    channel_d = '0;
    count_d   = '0;
    keep_d    = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (in_keep[i]) begin
        tagtime_d[int'(count_d)*TIME_WIDTH +: TIME_WIDTH] = in_tagtime[i*TIME_WIDTH +: TIME_WIDTH];
        channel_d[int'(count_d)*CHAN_WIDTH +: CHAN_WIDTH] = in_channel[i*CHAN_WIDTH +: CHAN_WIDTH];
        count_d = count_d + KW'(1);
      end
    end
    for (int j = 0; j < WORD_WIDTH; j++) begin
      keep_d[j] = (KW'(j) < count_d);
    end
    valid_d = |in_keep;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      tagtime_q <= '0;
      channel_q <= '0;
      keep_q    <= '0;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      tagtime_q <= tagtime_d;
      channel_q <= channel_d;
      keep_q    <= keep_d;
      count_q   <= count_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_tagtime = tagtime_q;
  assign out_channel = channel_q;
  assign out_keep    = keep_q;
  assign out_count   = count_q;

endmodule : lane_compactor
`default_nettype wire

// File: rtl/tag_channel_filter.sv
`default_nettype none
// ============================================================================
// Module      : tag_channel_filter
// Description : Two-stage stream filter. Stage 1 drops events on disabled or
//               invalid channels; stage 2 compacts survivors into the low
//               lanes and suppresses empty words. Saturating pass/drop
//               counters and a sticky overflow flag expose the filtered rate.
// Revision    : 1.0 - initial release
// Ports       : clk, rst           - clock, async active-high reset
//               s_axis_*           - input stream (tready tied to 1)
//               m_axis_*           - output stream (tready expected high)
//               chan_enable        - runtime per-channel/edge enable mask
//               cnt_clear          - pulse: clear counters and overflow
//               passed_count       - events forwarded
//               dropped_count      - events masked, invalid or lost
//               overflow           - sticky: valid word seen with tready=0
// ============================================================================
module tag_channel_filter
  import tt_event_pkg::*;
#(
  parameter int WORD_WIDTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_axis_tvalid,
  output logic                                   s_axis_tready,
  input  logic [TIME_WIDTH*WORD_WIDTH-1:0]       s_axis_tagtime,
  input  logic signed [CHAN_WIDTH*WORD_WIDTH-1:0] s_axis_channel,
  input  logic [WORD_WIDTH-1:0]                  s_axis_tkeep,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic [TIME_WIDTH*WORD_WIDTH-1:0]       m_axis_tagtime,
  output logic signed [CHAN_WIDTH*WORD_WIDTH-1:0] m_axis_channel,
  output logic [WORD_WIDTH-1:0]                  m_axis_tkeep,
  input  logic [MASK_WIDTH-1:0]                  chan_enable,
  input  logic                                   cnt_clear,
  output logic [CNT_WIDTH-1:0]                   passed_count,
  output logic [CNT_WIDTH-1:0]                   dropped_count,
  output logic                                   overflow
);

  localparam int KW    = $clog2(WORD_WIDTH + 1);
  // One cycle can add n_drop plus a discarded word's n_keep to dropped_count.
  localparam int INC_W = $clog2(2 * WORD_WIDTH + 1);
  localparam int SUM_W = ((CNT_WIDTH > INC_W) ? CNT_WIDTH : INC_W) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  assign s_axis_tready = 1'b1;

  // ---------------------------------------------------------------- stage 1
  logic [WORD_WIDTH-1:0]            s1_keep_d,    s1_keep_q;
  logic [KW-1:0]                    s1_ndrop_d,   s1_ndrop_q;
  logic [TIME_WIDTH*WORD_WIDTH-1:0] s1_tagtime_d, s1_tagtime_q;
  logic [CHAN_WIDTH*WORD_WIDTH-1:0] s1_channel_d, s1_channel_q;

  always_comb begin
    logic signed [CHAN_WIDTH-1:0] lane_ch;
    lane_ch      = '0;
    s1_keep_d    = '0;
    s1_ndrop_d   = '0;
    s1_tagtime_d = s_axis_tagtime;
    s1_channel_d = s_axis_channel;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      lane_ch = s_axis_channel[i*CHAN_WIDTH +: CHAN_WIDTH];
      // Mask is applied in the same cycle as the word; no extra delay.
      s1_keep_d[i] = s_axis_tvalid & s_axis_tkeep[i] & chan_is_valid(lane_ch)
                   & chan_enable[chan_to_mask_bit(lane_ch)];
      if (s_axis_tvalid && s_axis_tkeep[i] && !s1_keep_d[i]) begin
        s1_ndrop_d = s1_ndrop_d + KW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_keep_q    <= '0;
      s1_ndrop_q   <= '0;
      s1_tagtime_q <= '0;
      s1_channel_q <= '0;
    end else begin
      s1_keep_q    <= s1_keep_d;
      s1_ndrop_q   <= s1_ndrop_d;
      s1_tagtime_q <= s1_tagtime_d;
      s1_channel_q <= s1_channel_d;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [KW-1:0] n_keep;
  logic [KW-1:0] s2_ndrop_d, s2_ndrop_q;
  logic [CHAN_WIDTH*WORD_WIDTH-1:0] comp_channel;

  lane_compactor #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_compactor (
    .clk         (clk),
    .rst         (rst),
    .in_keep     (s1_keep_q),
    .in_tagtime  (s1_tagtime_q),
    .in_channel  (s1_channel_q),
    .out_valid   (m_axis_tvalid),
    .out_tagtime (m_axis_tagtime),
    .out_channel (comp_channel),
    .out_keep    (m_axis_tkeep),
    .out_count   (n_keep)
  );

  assign m_axis_channel = comp_channel;

  // Drop count travels alongside the compacted word so both counters
  // update in the cycle the word is presented downstream.
  always_comb begin
    s2_ndrop_d = s1_ndrop_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_ndrop_q <= '0;
    end else begin
      s2_ndrop_q <= s2_ndrop_d;
    end
  end

  // -------------------------------------------------------------- counters
  logic [CNT_WIDTH-1:0] passed_d,   passed_q;
  logic [CNT_WIDTH-1:0] dropped_d,  dropped_q;
  logic                 overflow_d, overflow_q;

  always_comb begin
    logic             accepted;
    logic             discarded;
    logic [INC_W-1:0] pass_inc;
    logic [INC_W-1:0] drop_inc;
    logic [SUM_W-1:0] pass_sum;
    logic [SUM_W-1:0] drop_sum;

    accepted  = m_axis_tvalid & m_axis_tready;
    // No stall path: a refused word is lost and its events become drops.
    discarded = m_axis_tvalid & ~m_axis_tready;
    pass_inc  = accepted ? INC_W'(n_keep) : '0;
    drop_inc  = INC_W'(s2_ndrop_q) + (discarded ? INC_W'(n_keep) : INC_W'(0));
    pass_sum  = SUM_W'(passed_q) + SUM_W'(pass_inc);
    drop_sum  = SUM_W'(dropped_q) + SUM_W'(drop_inc);

    passed_d   = (pass_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(pass_sum);
    dropped_d  = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(drop_sum);
    overflow_d = overflow_q | discarded;

    // Clear wins over any same-cycle increment.
    if (cnt_clear) begin
      passed_d   = '0;
      dropped_d  = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      passed_q   <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      passed_q   <= passed_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
    end
  end

  assign passed_count  = passed_q;
  assign dropped_count = dropped_q;
  assign overflow      = overflow_q;

endmodule : tag_channel_filter
`default_nettype wire

// File: tb/tb_tag_channel_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tag_channel_filter
// Description : Scoreboard bench for tag_channel_filter. Expected output
//               words are pushed when a word is driven and popped when the
//               DUT emits one. A second instance with 3-bit counters
//               exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tag_channel_filter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [255:0] s_axis_tagtime;
  logic [23:0]  s_axis_channel;
  logic [3:0]   s_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [255:0] m_axis_tagtime;
  logic [23:0]  m_axis_channel;
  logic [3:0]   m_axis_tkeep;
  logic [35:0]  chan_enable;
  logic         cnt_clear;
  logic [31:0]  passed_count;
  logic [31:0]  dropped_count;
  logic         overflow;

  logic         sat_s_tready;
  logic         sat_m_tvalid;
  logic [255:0] sat_m_tagtime;
  logic [23:0]  sat_m_channel;
  logic [3:0]   sat_m_tkeep;
  logic [2:0]   sat_passed;
  logic [2:0]   sat_dropped;
  logic         sat_overflow;

  always #5 clk = ~clk;

  tag_channel_filter #(.WORD_WIDTH(W), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tagtime(s_axis_tagtime), .s_axis_channel(s_axis_channel),
    .s_axis_tkeep(s_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tagtime(m_axis_tagtime), .m_axis_channel(m_axis_channel),
    .m_axis_tkeep(m_axis_tkeep),
    .chan_enable(chan_enable), .cnt_clear(cnt_clear),
    .passed_count(passed_count), .dropped_count(dropped_count),
    .overflow(overflow)
  );

  tag_channel_filter #(.WORD_WIDTH(W), .CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(sat_s_tready),
    .s_axis_tagtime(s_axis_tagtime), .s_axis_channel(s_axis_channel),
    .s_axis_tkeep(s_axis_tkeep),
    .m_axis_tvalid(sat_m_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tagtime(sat_m_tagtime), .m_axis_channel(sat_m_channel),
    .m_axis_tkeep(sat_m_tkeep),
    .chan_enable(chan_enable), .cnt_clear(cnt_clear),
    .passed_count(sat_passed), .dropped_count(sat_dropped),
    .overflow(sat_overflow)
  );

  typedef struct {
    logic [255:0] t;
    logic [23:0]  c;
    logic [3:0]   k;
    int           cyc;
  } exp_t;

  exp_t    sb[$];
  int      n_checks  = 0;
  int      n_errors  = 0;
  int      cyc       = 0;
  longint  exp_passed  = 0;
  longint  exp_dropped = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] chans(input int a0, input int a1, input int a2, input int a3);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  function automatic logic [255:0] times(input longint t0, input longint t1,
                                         input longint t2, input longint t3);
    return {64'(t3), 64'(t2), 64'(t1), 64'(t0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Reference filter + compaction, evaluated against the mask in force now.
  task automatic send_word(input logic [255:0] t, input logic [23:0] c,
                           input logic [3:0] k, input logic v);
    exp_t e;
    int   n;
    int   nd;
    int   ch;
    logic ok;
    e.t = '0; e.c = '0; e.k = '0; e.cyc = 0;
    n = 0; nd = 0;
    for (int i = 0; i < W; i++) begin
      ch = int'($signed(c[i*6 +: 6]));
      ok = 1'b0;
      if (v && k[i]) begin
        if (ch >= 1 && ch <= 18)        ok = chan_enable[ch - 1];
        else if (ch <= -1 && ch >= -18) ok = chan_enable[17 - ch];
        if (ok) begin
          e.t[n*64 +: 64] = t[i*64 +: 64];
          e.c[n*6 +: 6]   = c[i*6 +: 6];
          e.k[n]          = 1'b1;
          n++;
        end else begin
          nd++;
        end
      end
    end
    exp_passed  += n;
    exp_dropped += nd;
    if (n > 0) begin
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
    s_axis_tvalid  = v;
    s_axis_tagtime = t;
    s_axis_channel = c;
    s_axis_tkeep   = k;
    tick();
    s_axis_tvalid  = 1'b0;
    s_axis_tkeep   = '0;
  endtask

  task automatic chk_counts();
    check("passed_count", passed_count, exp_passed[31:0]);
    check("dropped_count", dropped_count, exp_dropped[31:0]);
  endtask

  // Output monitor: every emitted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_word", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", cyc, e.cyc);
        check("m_tagtime", m_axis_tagtime, e.t);
        check("m_channel", m_axis_channel, e.c);
        check("m_tkeep", m_axis_tkeep, e.k);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    s_axis_tvalid  = 1'b0;
    s_axis_tagtime = '0;
    s_axis_channel = '0;
    s_axis_tkeep   = '0;
    m_axis_tready  = 1'b1;
    chan_enable    = '1;
    cnt_clear      = 1'b0;
    rst            = 1'b1;
    idle(3);

    check("rst_s_tready", s_axis_tready, 1);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tkeep", m_axis_tkeep, 0);
    check("rst_m_tagtime", m_axis_tagtime, 0);
    check("rst_m_channel", m_axis_channel, 0);
    check("rst_passed", passed_count, 0);
    check("rst_dropped", dropped_count, 0);
    check("rst_overflow", overflow, 0);

    rst = 1'b0;
    idle(1);

    // All lanes pass unchanged.
    send_word(times(100, 200, 300, 400), chans(1, -1, 18, -18), 4'hF, 1'b1);
    idle(3);
    chk_counts();

    // Only rising channel 2 enabled.
    chan_enable = 36'h2;
    send_word(times(10, 20, 30, 40), chans(2, 3, 2, -2), 4'hF, 1'b1);
    idle(3);
    chk_counts();

    // Invalid channels dropped regardless of mask.
    chan_enable = '1;
    send_word(times(5, 6, 7, 8), chans(0, 19, -19, 5), 4'hF, 1'b1);
    idle(3);
    chk_counts();

    // Whole word masked: no output at all.
    chan_enable = 36'hF_FFFF_FFFE;
    send_word(times(1, 2, 3, 4), chans(1, 1, 1, 1), 4'hF, 1'b1);
    idle(3);
    chk_counts();

    // tkeep without tvalid is ignored.
    chan_enable = '1;
    send_word(times(9, 9, 9, 9), chans(1, 2, 3, 4), 4'hF, 1'b0);
    idle(3);
    chk_counts();

    // Refused 3-event word: discarded, counted as dropped, overflow set.
    send_word(times(11, 12, 13, 14), chans(3, 4, 5, 6), 4'b0111, 1'b1);
    tick();
    m_axis_tready = 1'b0;
    tick();
    m_axis_tready = 1'b1;
    exp_passed  -= 3;
    exp_dropped += 3;
    check("overflow_set", overflow, 1);
    send_word(times(21, 22, 23, 24), chans(-3, 7, 8, 9), 4'b0011, 1'b1);
    idle(3);
    chk_counts();
    check("overflow_sticky", overflow, 1);

    // Clear in the same cycle as a 2-event increment: clear wins.
    send_word(times(31, 32, 33, 34), chans(1, 2, 0, 0), 4'b0011, 1'b1);
    tick();
    cnt_clear = 1'b1;
    tick();
    cnt_clear   = 1'b0;
    exp_passed  = 0;
    exp_dropped = 0;
    chk_counts();
    check("overflow_cleared", overflow, 0);

    // Back-to-back words; 3-bit counters saturate at 7.
    send_word(times(41, 42, 43, 44), chans(1, 2, 3, 4), 4'hF, 1'b1);
    send_word(times(51, 52, 53, 54), chans(-4, -3, -2, -1), 4'hF, 1'b1);
    idle(3);
    check("sat_passed", sat_passed, 3'd7);
    send_word(times(0, 0, 0, 0), chans(0, 0, 0, 0), 4'hF, 1'b1);
    send_word(times(0, 0, 0, 0), chans(20, -20, 31, -32), 4'hF, 1'b1);
    idle(3);
    check("sat_dropped", sat_dropped, 3'd7);
    chk_counts();

    // Async reset with a word in flight.
    send_word(times(61, 62, 63, 64), chans(1, 2, 3, 4), 4'hF, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    check("arst_m_tvalid", m_axis_tvalid, 0);
    check("arst_m_tkeep", m_axis_tkeep, 0);
    check("arst_passed", passed_count, 0);
    check("arst_dropped", dropped_count, 0);
    sb.delete();
    exp_passed  = 0;
    exp_dropped = 0;
    idle(2);
    rst = 1'b0;
    idle(1);
    send_word(times(71, 72, 73, 74), chans(5, -5, 6, 0), 4'b1111, 1'b1);
    idle(3);
    chk_counts();

    idle(3);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_tag_channel_filter
`default_nettype wire

// File: doc/tag_channel_filter.md
Name: tag_channel_filter

Overview:
- Pipelined stream stage placed directly upstream of the measurement stage.
- Drops events whose channel is disabled in a runtime enable mask, or whose channel number is invalid.
- Compacts the surviving events into the low lanes of each word and suppresses words left empty.
- Keeps saturating pass/drop counters and a sticky overflow flag so firmware can see the filtered rate.

Parameters:
- WORD_WIDTH, 4, number of event lanes per word; must be ≥1 and must equal the downstream WORD_WIDTH.
- CNT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  constant 1; this stage never backpressures.
- s_axis_tagtime  in  64 x WORD_WIDTH  tag time, 1/3 ps units.
- s_axis_channel  in  signed 6 x WORD_WIDTH  +1..+18 rising edge, -1..-18 falling edge.
- s_axis_tkeep  in  WORD_WIDTH  per-lane event valid.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready; expected to be always 1.
- m_axis_tagtime  out  64 x WORD_WIDTH  compacted tag times.
- m_axis_channel  out  signed 6 x WORD_WIDTH  compacted channels.
- m_axis_tkeep  out  WORD_WIDTH  thermometer code, lanes 0..n-1 set.
- chan_enable  in  36  bit c-1 enables rising channel c; bit 17+c enables falling channel -c.
- cnt_clear  in  1  single-cycle pulse; clears counters and the overflow flag.
- passed_count  out  CNT_WIDTH  events forwarded.
- dropped_count  out  CNT_WIDTH  events removed: masked, invalid channel, or lost to overflow.
- overflow  out  1  sticky; set when a valid output word was not accepted.

Behaviour:
- Reset state: m_axis_tvalid=0, m_axis_tkeep=0, m_axis data=0, passed_count=0, dropped_count=0, overflow=0, all pipeline valids 0.
- Latency is fixed at 2 cycles, input word to output word.
- Stage 1 (register): lane_keep[i] = s_axis_tkeep[i] & s_axis_tvalid & channel_ok(i) & chan_enable[bit(i)].
  - channel_ok means 1 ≤ |channel| ≤ 18.
  - Channel 0, or any value with |channel| > 18, is dropped regardless of the mask.
- chan_enable is sampled in the same cycle as the input word. A mask change applies to the word arriving in that cycle, with no extra delay.
- Stage 1 also registers n_drop = popcount(s_axis_tkeep & ~lane_keep), computed only when s_axis_tvalid=1.
- Stage 2 (register): each kept lane i moves to output lane prefix_count(lane_keep[0..i-1]).
  - Relative lane order is preserved.
  - Unused output lanes carry data 0 and tkeep 0.
  - m_axis_tvalid = (n_keep ≠ 0). Empty words are never emitted.
- Overflow rule: if m_axis_tvalid=1 and m_axis_tready=0 in a cycle:
  - the word is discarded (no stall);
  - overflow is set;
  - n_keep is added to dropped_count instead of passed_count.
- Counters update at stage 2 and saturate at 2^CNT_WIDTH-1; they never wrap.
  - passed_count += n_keep when the word is accepted.
  - dropped_count += n_drop, plus n_keep for a discarded word.
- Clear vs. increment: cnt_clear in the same cycle as an increment wins; counters become 0 and that cycle's counts are lost.
- s_axis_tvalid=0 while s_axis_tkeep≠0: the word is ignored entirely and nothing is counted.
- Reset asserted mid-stream: in-flight words are discarded and outputs return to the reset state asynchronously.
  - First valid output appears 2 cycles after the first input word following rst deassertion.

Decomposition:
- Package tt_event_pkg:
  - NUM_CHANNELS=18, MASK_WIDTH=36;
  - function chan_to_mask_bit(signed [5:0]) returning the bit index;
  - function chan_is_valid.
- Sub-module lane_compactor: parameterised by WORD_WIDTH.
  - Inputs: keep vector plus lane data. Outputs: compacted lanes, thermometer tkeep, count.
  - One register stage; instantiated as stage 2.

Test Plan:
- Reset, all mask bits 1, tkeep=4'b1111, channels {1,-1,18,-18} -> identical word 2 cycles later; tkeep=4'b1111; passed_count=4.
- Mask enables only bit 1 (channel +2); channels {2,3,2,-2}, tkeep=4'b1111, times {10,20,30,40} -> out lanes {2@10, 2@30}; tkeep=4'b0011; dropped_count=2.
- Channels {0,19,-19,5}, all mask bits 1 -> single event 5 in lane 0; dropped_count=3.
- Channels {1,1,1,1}, mask bit 0 = 0 -> no m_axis_tvalid pulse; dropped_count=4; passed_count unchanged.
- m_axis_tready=0 for one cycle while a 3-event word is output -> overflow=1; dropped_count+=3; next word passes normally.
- Preload passed_count to 2^32-2, send 4 events -> count saturates at 0xFFFFFFFF. Pulse cnt_clear together with a 2-event word -> both counters 0 and overflow 0 the following cycle.
